// File: rtl/keypad_entry.sv
// Debounced keypad entry: turns raw scanner key_down/key_code into up to three
// decimal digits plus enter, backspace, clear-entry and command key events.
module keypad_entry #(
  parameter int STABLE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_down,
  input  logic [3:0] key_code,
  input  logic       clear,
  output logic [9:0] entry_value,
  output logic [1:0] entry_digits,
  output logic       num_valid,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic       err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      code_q;
  logic [CW-1:0]   cnt_inc;
  logic            cnt_done;
  logic            accept;
  logic [13:0]     append_sum;
  logic [9:0]      append_value;
  logic [9:0]      shifted_down;

  assign cnt_inc      = cnt + CW'(1);
  assign cnt_done     = (cnt_inc == CW'(STABLE_CYCLES));
  assign append_sum   = 14'(entry_value) * 14'd10 + 14'(key_code);
  assign append_value = (append_sum > 14'd999) ? 10'd999 : append_sum[9:0];
  assign shifted_down = entry_value / 10'd10;

  // A key is accepted on the edge that would record its STABLE_CYCLES-th stable sample
  always_comb begin
    accept = 1'b0;
    case (state)
      IDLE:     accept = key_down && (STABLE_CYCLES == 1);
      PRESS_DB: accept = key_down && (key_code == code_q) && cnt_done;
      default:  accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      code_q       <= '0;
      entry_value  <= '0;
      entry_digits <= '0;
      cmd_code     <= '0;
      num_valid    <= 1'b0;
      cmd_valid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;

      case (state)
        IDLE: begin
          if (key_down) begin
            code_q <= key_code;
            if (accept) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              state <= PRESS_DB;
              cnt   <= CW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (!key_down) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (key_code != code_q) begin
            code_q <= key_code;
            cnt    <= CW'(1);
          end else if (accept) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (!key_down) begin
            if (STABLE_CYCLES == 1) begin
              state <= IDLE;
            end else begin
              state <= RELEASE_DB;
              cnt   <= CW'(1);
            end
          end
        end
        RELEASE_DB: begin
          if (key_down) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // Command keys survive a concurrent clear; entry-editing keys do not
      if (accept) begin
        if (key_code >= 4'hD) begin
          cmd_code  <= key_code;
          cmd_valid <= 1'b1;
        end else if (!clear) begin
          if (key_code <= 4'd9) begin
            if (entry_digits != 2'd3) begin
              entry_value  <= append_value;
              entry_digits <= entry_digits + 2'd1;
            end else begin
              err <= 1'b1;
            end
          end else if (key_code == 4'hA) begin
            if (entry_digits != 2'd0) num_valid <= 1'b1;
            else                      err       <= 1'b1;
          end else if (key_code == 4'hB) begin
            if (entry_digits != 2'd0) begin
              entry_value  <= shifted_down;
              entry_digits <= entry_digits - 2'd1;
            end
          end else begin
            entry_value  <= '0;
            entry_digits <= '0;
          end
        end
      end

      // The committed number stays visible for the num_valid cycle, then empties
      if (clear || num_valid) begin
        entry_value  <= '0;
        entry_digits <= '0;
      end
    end
  end

endmodule
